md_unit: RTL and testbench

- Multiply/divide unit and HI/LO register controller for the E stage of the P7 pipeline. It sits beside the ALU.
- It accepts mult/multu/div/divu from E and performs them over a fixed multi-cycle busy window.
- It services mthi/mtlo writes and supplies HI/LO to mfhi/mflo.
- Its busy/start status feeds the hazard unit, which stalls md-class instructions in D. The CP0 request line cancels an op issuing in the same cycle.

---
 rtl/md_unit_pkg.sv | 19 +
 rtl/md_calc.sv | 34 +++
 rtl/md_unit.sv | 72 +++++++
 tb/tb_md_unit.sv | 118 +++++++++++
 4 files changed

// File: rtl/md_unit_pkg.sv
// md_unit_pkg: operation codes and helpers shared by the multiply/divide unit
package md_unit_pkg;
   localparam int MDOP_WIDTH = 3;
   typedef enum logic [MDOP_WIDTH-1:0] {
      MDOP_NONE  = 3'd0,
      MDOP_MULT  = 3'd1,
      MDOP_MULTU = 3'd2,
      MDOP_DIV   = 3'd3,
      MDOP_DIVU  = 3'd4,
      MDOP_MTHI  = 3'd5,
      MDOP_MTLO  = 3'd6
   } mdop_e;
   function automatic logic is_arith(input logic [MDOP_WIDTH-1:0] op);
      return op inside {MDOP_MULT, MDOP_MULTU, MDOP_DIV, MDOP_DIVU};
   endfunction
   function automatic logic is_div(input logic [MDOP_WIDTH-1:0] op);
      return op inside {MDOP_DIV, MDOP_DIVU};
   endfunction
endpackage

// File: rtl/md_calc.sv
// md_calc: combinational 32x32 multiply / divide producing {hi,lo} and a divide-by-zero flag
//   mdop_i  operation code
//   a_i     rs operand (multiplicand / dividend)
//   b_i     rt operand (multiplier / divisor)
//   res_o   {hi,lo}: product, or {remainder,quotient}
//   div0_o  divide op with zero divisor
module md_calc
   import md_unit_pkg::*;
(
   input  logic [MDOP_WIDTH-1:0] mdop_i,
   input  logic [31:0]           a_i,
   input  logic [31:0]           b_i,
   output logic [63:0]           res_o,
   output logic                  div0_o
);
   logic        sgn, a_neg, b_neg;
   logic [31:0] a_mag, b_mag, q_mag, r_mag, q, r;
   logic [63:0] prod;
   assign sgn   = mdop_i inside {MDOP_MULT, MDOP_DIV};
   assign a_neg = sgn & a_i[31];
   assign b_neg = sgn & b_i[31];
   // low 64 bits of the sign- or zero-extended product serve both mult and multu
   assign prod  = {{32{a_neg}}, a_i} * {{32{b_neg}}, b_i};
   // divide magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow case;
   // a zero divisor is replaced to keep the datapath defined, the result is discarded
   assign a_mag = a_neg ? -a_i : a_i;
   assign b_mag = (b_i == 32'd0) ? 32'd1 : (b_neg ? -b_i : b_i);
   assign q_mag = a_mag / b_mag;
   assign r_mag = a_mag % b_mag;
   assign q     = (a_neg ^ b_neg) ? -q_mag : q_mag;
   assign r     = a_neg ? -r_mag : r_mag;
   assign res_o  = is_div(mdop_i) ? {r, q} : prod;
   assign div0_o = is_div(mdop_i) & (b_i == 32'd0);
endmodule

// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers for the E stage
//   clk, reset  clock and asynchronous active-high reset
//   start       md instruction valid in E this cycle
//   mdop        operation code
//   A, B        rs / rt operands
//   req         exception/interrupt request, cancels this cycle's issue
//   busy        operation in flight
//   hi, lo      architectural HI / LO registers
module md_unit
   import md_unit_pkg::*;
#(
   parameter int unsigned MULT_CYC = 5,
   parameter int unsigned DIV_CYC  = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [MDOP_WIDTH-1:0] mdop,
   input  logic [31:0]           A,
   input  logic [31:0]           B,
   input  logic                  req,
   output logic                  busy,
   output logic [31:0]           hi,
   output logic [31:0]           lo
);
   localparam int CW = $clog2(MULT_CYC > DIV_CYC ? MULT_CYC : DIV_CYC) + 1;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
   logic          div0_q, div0_d;
   logic [63:0]   res;
   logic          div0, idle, ok, issue, fin;
   md_calc u_calc (
      .mdop_i (mdop),
      .a_i    (A),
      .b_i    (B),
      .res_o  (res),
      .div0_o (div0)
   );
   assign idle  = cnt_q == '0;
   assign ok    = start & idle & ~req;
   assign issue = ok & is_arith(mdop);
   // the edge ending the last busy cycle commits the pending result
   assign fin   = cnt_q == CW'(1);
   always_comb begin
      cnt_d  = issue ? (is_div(mdop) ? CW'(DIV_CYC) : CW'(MULT_CYC)) : (idle ? cnt_q : cnt_q - 1'b1);
      phi_d  = issue ? res[63:32] : phi_q;
      plo_d  = issue ? res[31:0] : plo_q;
      div0_d = issue ? div0 : div0_q;
      hi_d   = (fin & ~div0_q) ? phi_q : (ok & (mdop == MDOP_MTHI)) ? A : hi_q;
      lo_d   = (fin & ~div0_q) ? plo_q : (ok & (mdop == MDOP_MTLO)) ? A : lo_q;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q  <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         phi_q  <= '0;
         plo_q  <= '0;
         div0_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
         phi_q  <= phi_d;
         plo_q  <= plo_d;
         div0_q <= div0_d;
      end
   end
   assign busy = ~idle;
   assign hi   = hi_q;
   assign lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: randomized and directed checks of md_unit against an arithmetic reference model
module tb_md_unit;
   localparam int MULT_CYC = 5;
   localparam int DIV_CYC  = 10;
   logic        clk = 1'b0, reset = 1'b1, start = 1'b0, req = 1'b0;
   logic [2:0]  mdop = 3'd0;
   logic [31:0] A = '0, B = '0;
   logic        busy;
   logic [31:0] hi, lo;
   logic [63:0] m_hl = '0;
   int          n_tests = 0, n_fail = 0;
   md_unit #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
      .clk(clk), .reset(reset), .start(start), .mdop(mdop), .A(A), .B(B),
      .req(req), .busy(busy), .hi(hi), .lo(lo)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [63:0] hl);
      longint sa, sb, q, r;
      longint unsigned ua, ub;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (op)
         3'd1: return 64'(sa * sb);
         3'd2: return 64'(ua * ub);
         3'd3: begin
            if (b == 0) return hl;
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
         end
         3'd4: return (b == 0) ? hl : {32'(ua % ub), 32'(ua / ub)};
         3'd5: return {a, hl[31:0]};
         3'd6: return {hl[63:32], a};
         default: return hl;
      endcase
   endfunction
   // poke: 0 nothing, 1 hold req high while busy, 2 attempt MTHI 0xDEAD in the first busy cycle
   task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit rq, input int poke, input string tag);
      int cyc, exp_cyc;
      bit acc;
      @(negedge clk);
      start = 1'b1; mdop = op; A = a; B = b; req = rq;
      @(negedge clk);
      start = 1'b0; mdop = 3'd0; req = 1'b0;
      cyc = 0;
      while (busy && cyc < 100) begin
         cyc++;
         if (poke == 1) req = 1'b1;
         if (poke == 2) begin
            start = (cyc == 1); mdop = 3'd5; A = 32'hDEAD;
         end
         @(negedge clk);
      end
      start = 1'b0; req = 1'b0; mdop = 3'd0;
      acc = !rq && (op >= 3'd1 && op <= 3'd6);
      exp_cyc = (acc && op inside {3'd1, 3'd2}) ? MULT_CYC : (acc && op inside {3'd3, 3'd4}) ? DIV_CYC : 0;
      if (acc) m_hl = ref_md(op, a, b, m_hl);
      check({tag, " cycles"}, 64'(cyc), 64'(exp_cyc));
      check({tag, " hilo"}, {hi, lo}, m_hl);
   endtask
   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'(int'($urandom_range(0, 20)) - 10);
         default: return $urandom;
      endcase
   endfunction
   initial begin
      repeat (2) @(negedge clk);
      check("reset busy", 64'(busy), 64'd0);
      check("reset hilo", {hi, lo}, 64'd0);
      reset = 1'b0;
      run(3'd1, 32'hFFFF_FFFE, 32'd3, 0, 0, "mult");
      check("mult const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
      run(3'd2, 32'hFFFF_FFFE, 32'd3, 0, 0, "multu");
      check("multu const", {hi, lo}, 64'h0000_0002_FFFF_FFFA);
      run(3'd3, 32'hFFFF_FFF9, 32'd2, 0, 0, "div");
      check("div const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
      run(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, "div ovf");
      check("div ovf const", {hi, lo}, 64'h0000_0000_8000_0000);
      run(3'd5, 32'h11, 32'd0, 0, 0, "mthi");
      run(3'd6, 32'h22, 32'd0, 0, 0, "mtlo");
      run(3'd4, 32'd5, 32'd0, 0, 0, "divu0");
      check("divu0 const", {hi, lo}, 64'h0000_0011_0000_0022);
      run(3'd1, 32'd7, 32'd9, 1, 0, "req mult");
      run(3'd3, 32'd100, 32'd7, 0, 1, "req in flight");
      run(3'd1, 32'd1234, 32'd5678, 0, 2, "mthi while busy");
      for (int i = 0; i < 40; i++) run(3'($urandom_range(0, 7)), pick(), pick(), $urandom_range(0, 5) == 0, 0, $sformatf("rnd%0d", i));
      run(3'd5, 32'h33, 32'd0, 0, 0, "pre reset");
      @(negedge clk);
      start = 1'b1; mdop = 3'd1; A = 32'd7; B = 32'd9;
      @(negedge clk);
      start = 1'b0; mdop = 3'd0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check("async reset busy", 64'(busy), 64'd0);
      check("async reset hilo", {hi, lo}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (8) @(negedge clk);
      check("post reset busy", 64'(busy), 64'd0);
      check("post reset hilo", {hi, lo}, 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
